// File: rtl/cart_loader.sv
// cart_loader: buffers HPS ioctl download bytes in a small FIFO and commits
// them to an acknowledged cartridge memory port, deriving the console's
// cartridge qualifiers (page count, SG-1000 flag, SG-1000 extra-RAM hole).
//
// Ports:
//   clk_sys, reset          clock, asynchronous active-high reset
//   ioctl_download/wr/addr/dout/index   HPS download stream
//   ioctl_wait              registered back-pressure to the host
//   mem_addr/mem_din/mem_we write request, held until mem_ack
//   mem_ack                 write accepted
//   cart_pages              ioctl_addr[19:14] of the last accepted byte
//   sg1000, extram          image qualifiers
//   load_busy, load_done    download/drain status, completion pulse
//   overflow                sticky dropped-byte flag, cleared per download
module cart_loader #(
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic [5:0]        cart_pages,
   output logic              sg1000,
   output logic              extram,
   output logic              load_busy,
   output logic              load_done,
   output logic              overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

   entry_t           fifo_mem [FIFO_DEPTH];
   entry_t           head_c;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;

   state_t state;
   state_t state_d;
   logic   load_c;
   logic   pop_c;

   logic in_range_c;
   logic fifo_full_c;
   logic push_c;
   logic drop_c;
   logic dl_q;
   logic dl_rise_c;
   logic done_c;

   // Only the low five index bits identify the image type.
   logic unused_index_bits;
   assign unused_index_bits = ^ioctl_index[7:5];

   // Accept / drop decision for the incoming strobe.
   assign in_range_c  = (ioctl_addr >> ADDR_W) == 25'd0;
   assign fifo_full_c = (count == CNT_W'(FIFO_DEPTH));
   assign push_c      = ioctl_wr & ioctl_download & ~fifo_full_c & in_range_c;
   assign drop_c      = ioctl_wr & ioctl_download & ~push_c;
   assign count_next  = count + CNT_W'(push_c) - CNT_W'(pop_c);
   assign head_c      = fifo_mem[rd_ptr];

   assign dl_rise_c = ioctl_download & ~dl_q;
   // Completion looks at next-cycle occupancy/state so it lands one cycle after the last pop.
   assign done_c    = load_busy & ~ioctl_download & (count_next == '0) & (state_d == S_IDLE);

   // FIFO storage (data only, no reset needed).
   always_ff @(posedge clk_sys) begin
      if (push_c) begin
         fifo_mem[wr_ptr] <= '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};
      end
   end

   // Write FSM next-state logic.
   always_comb begin
      state_d = state;
      load_c  = 1'b0;
      pop_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               state_d = S_WRITE;
               load_c  = 1'b1;
            end
         end
         S_WRITE: begin
            if (mem_ack) begin
               state_d = S_GAP;
               pop_c   = 1'b1;
            end
         end
         // One idle cycle so a registered ack is never counted twice.
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, FIFO bookkeeping, memory port, qualifiers and status.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_we     <= 1'b0;
         ioctl_wait <= 1'b0;
         cart_pages <= '0;
         sg1000     <= 1'b0;
         extram     <= 1'b0;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
         overflow   <= 1'b0;
         dl_q       <= 1'b0;
      end else begin
         state      <= state_d;
         count      <= count_next;
         ioctl_wait <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
         dl_q       <= ioctl_download;
         load_done  <= done_c;

         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);

         if (load_c) begin
            mem_addr <= head_c.addr;
            mem_din  <= head_c.data;
            mem_we   <= 1'b1;
         end else if (pop_c) begin
            mem_we   <= 1'b0;
         end

         if (push_c) begin
            cart_pages <= ioctl_addr[19:14];
            if (ioctl_addr == 25'd0) begin
               extram <= 1'b0;
               sg1000 <= (ioctl_index[4:0] == 5'd2);
            end else if ((ioctl_addr[24:13] == 12'd1) && sg1000) begin
               // The byte at 0x2000 restarts the all-0xFF tracking.
               extram <= ((ioctl_addr[12:0] == 13'd0) | extram) & (ioctl_dout == 8'hFF);
            end
         end

         if (dl_rise_c) begin
            overflow  <= 1'b0;
            load_busy <= 1'b1;
         end else if (done_c) begin
            load_busy <= 1'b0;
         end

         if (drop_c) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cart_loader.sv
// Self-checking bench for cart_loader: drives ioctl downloads, models the
// memory ack with a configurable delay and compares committed writes and
// qualifiers against a behavioural model of the download rules.
module tb_cart_loader;

   logic        clk_sys;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;
   logic [19:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic        mem_ack;
   logic [5:0]  cart_pages;
   logic        sg1000;
   logic        extram;
   logic        load_busy;
   logic        load_done;
   logic        overflow;

   cart_loader #(.ADDR_W(20), .FIFO_DEPTH(4)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .ioctl_wait     (ioctl_wait),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_we         (mem_we),
      .mem_ack        (mem_ack),
      .cart_pages     (cart_pages),
      .sg1000         (sg1000),
      .extram         (extram),
      .load_busy      (load_busy),
      .load_done      (load_done),
      .overflow       (overflow)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   int errors = 0;
   int checks = 0;

   // Memory-side ack model: ack arrives ack_delay cycles after mem_we rises.
   bit ack_en    = 1'b0;
   int ack_delay = 1;
   int wcnt      = 0;

   always @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mem_ack <= 1'b0;
         wcnt    <= 0;
      end else if (!ack_en || !mem_we) begin
         mem_ack <= 1'b0;
         wcnt    <= 0;
      end else begin
         wcnt    <= wcnt + 1;
         mem_ack <= ((wcnt + 1) == ack_delay);
      end
   end

   // Reference model: expected/observed write streams and FIFO occupancy.
   typedef logic [27:0] wr_t;
   wr_t exp_q[$];
   wr_t got_q[$];
   int  model_occ      = 0;
   int  edge_no        = 0;
   int  last_pop_edge  = 0;
   int  done_edge      = 0;
   int  done_cnt       = 0;
   int  done_during_dl = 0;
   int  wait_seen      = 0;
   bit  m_acc;
   bit  m_pop;

   always @(posedge clk_sys) begin
      edge_no++;
      if (reset) begin
         model_occ = 0;
      end else begin
         m_pop = mem_we && mem_ack;
         m_acc = ioctl_wr && ioctl_download && (ioctl_addr < 25'h100000) && (model_occ < 4);
         if (m_pop) begin
            got_q.push_back({mem_addr, mem_din});
            last_pop_edge = edge_no;
         end
         if (m_acc) exp_q.push_back({ioctl_addr[19:0], ioctl_dout});
         model_occ = model_occ + int'(m_acc) - int'(m_pop);
         if (load_done) begin
            done_cnt++;
            done_edge = edge_no;
            if (ioctl_download) done_during_dl++;
         end
         if (ioctl_wait) wait_seen++;
      end
   end

   // Back-pressure tracking: ioctl_wait must mirror post-edge occupancy >= 3.
   bit chk_wait = 1'b0;
   int wait_bad = 0;
   int wait_hi  = 0;

   always @(negedge clk_sys) begin
      if (chk_wait && !reset) begin
         if (ioctl_wait !== (model_occ >= 3)) wait_bad++;
         if (ioctl_wait) wait_hi++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int write_mismatches();
      int n;
      int m;
      n = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                        : exp_q.size() - got_q.size();
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) n++;
      return n;
   endfunction

   task automatic clear_model();
      exp_q.delete();
      got_q.delete();
      done_cnt       = 0;
      done_during_dl = 0;
      wait_seen      = 0;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honour);
      int n;
      n = 0;
      while (honour && ioctl_wait && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_wait_timeout: ioctl_wait still %b after %0d cycles, required 0", ioctl_wait, n);
      end
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_download(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic end_download();
      int n;
      n = 0;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      while (load_busy && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: load_busy still %b after %0d cycles, required 0", load_busy, n);
      end
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      checks++;
      if ({ioctl_wait, mem_we, load_busy, load_done, overflow, sg1000, extram, cart_pages, mem_addr, mem_din} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b wait=%b busy=%b done=%b ovf=%b sg=%b ext=%b pages=%h addr=%h din=%h, required all 0",
                  mem_we, ioctl_wait, load_busy, load_done, overflow, sg1000, extram, cart_pages, mem_addr, mem_din);
      end
      reset = 1'b0;
      @(negedge clk_sys);
      clear_model();
   endtask

   task automatic test_basic();
      ack_en    = 1'b1;
      ack_delay = 1;
      clear_model();
      start_download(8'd0);
      send_byte(25'd0, 8'hA0, 1'b0);
      checks++;
      if (mem_we !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency1: mem_we=%b one cycle after strobe, required 0", mem_we);
      end
      @(negedge clk_sys);
      checks++;
      if ({mem_we, mem_addr, mem_din} !== {1'b1, 20'd0, 8'hA0}) begin
         errors++;
         $display("FAIL basic_latency2: we=%b addr=%h din=%h, required we=1 addr=00000 din=a0", mem_we, mem_addr, mem_din);
      end
      for (int i = 1; i < 16; i++) begin
         repeat (6) @(negedge clk_sys);
         send_byte(25'(i), 8'(8'hA0 + i), 1'b0);
      end
      end_download();
      checks++;
      if (got_q.size() !== 16 || write_mismatches() !== 0) begin
         errors++;
         $display("FAIL basic_writes: got %0d writes with %0d mismatches, required 16 in order", got_q.size(), write_mismatches());
      end
      checks++;
      if (wait_seen !== 0) begin
         errors++;
         $display("FAIL basic_wait: ioctl_wait high for %0d cycles, required 0", wait_seen);
      end
      checks++;
      if (done_cnt !== 1 || done_during_dl !== 0) begin
         errors++;
         $display("FAIL basic_done_count: %0d pulses (%0d during download), required 1 (0)", done_cnt, done_during_dl);
      end
      // load_done is registered one cycle after the last pop, so it is sampled two edges later.
      checks++;
      if (done_edge !== last_pop_edge + 2) begin
         errors++;
         $display("FAIL basic_done_timing: done sampled at edge %0d, required %0d", done_edge, last_pop_edge + 2);
      end
      checks++;
      if ({cart_pages, load_busy, overflow} !== 8'd0) begin
         errors++;
         $display("FAIL basic_status: pages=%0d busy=%b ovf=%b, required 0/0/0", cart_pages, load_busy, overflow);
      end
   endtask

   task automatic test_back_to_back();
      ack_en    = 1'b1;
      ack_delay = 5;
      clear_model();
      wait_bad = 0;
      wait_hi  = 0;
      start_download(8'd1);
      chk_wait = 1'b1;
      for (int i = 0; i < 64; i++) send_byte(25'($urandom_range(0, 32'hFFFFF)), 8'($urandom), 1'b1);
      end_download();
      chk_wait = 1'b0;
      checks++;
      if (wait_bad !== 0) begin
         errors++;
         $display("FAIL burst_wait_track: %0d cycles where ioctl_wait disagreed with occupancy>=3, required 0", wait_bad);
      end
      checks++;
      if (wait_hi == 0) begin
         errors++;
         $display("FAIL burst_wait_seen: ioctl_wait high for %0d cycles, required >0", wait_hi);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL burst_overflow: overflow=%b, required 0", overflow);
      end
      checks++;
      if (got_q.size() !== 64 || write_mismatches() !== 0) begin
         errors++;
         $display("FAIL burst_writes: got %0d writes with %0d mismatches, required 64 in order", got_q.size(), write_mismatches());
      end
      ack_delay = 1;
   endtask

   task automatic test_overflow();
      ack_en = 1'b0;
      clear_model();
      start_download(8'd0);
      for (int i = 0; i < 8; i++) send_byte(25'($urandom_range(0, 32'hFFFF)), 8'($urandom), 1'b0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: overflow=%b, required 1", overflow);
      end
      ack_en    = 1'b1;
      ack_delay = 1;
      end_download();
      checks++;
      if (got_q.size() !== 4 || write_mismatches() !== 0) begin
         errors++;
         $display("FAIL ovf_writes: got %0d writes with %0d mismatches, required first 4 bytes", got_q.size(), write_mismatches());
      end
      start_download(8'd0);
      checks++;
      if (overflow !== 1'b0 || load_busy !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clear: overflow=%b busy=%b after new download, required 0/1", overflow, load_busy);
      end
      end_download();
   endtask

   task automatic test_sg1000();
      logic [24:0] addrs [8];
      logic [7:0]  datas [8];
      logic [7:0]  idx;
      bit          exp_sg;
      bit          exp_ext;
      bit          hole_seen;
      ack_en    = 1'b1;
      ack_delay = 1;
      for (int pass = 0; pass < 3; pass++) begin
         clear_model();
         idx = 8'($urandom);
         if (pass < 2) idx[4:0] = 5'd2;
         else if (idx[4:0] == 5'd2) idx[0] = 1'b1;
         addrs[0] = 25'd0;
         addrs[1] = 25'(32'h100 + $urandom_range(0, 32'hE00));
         addrs[2] = 25'h2000;
         addrs[3] = 25'(32'h2000 + $urandom_range(1, 32'hFF));
         addrs[4] = 25'h2100;
         addrs[5] = 25'(32'h2100 + $urandom_range(1, 32'h1E00));
         addrs[6] = 25'h3FFF;
         addrs[7] = 25'(32'h4000 + $urandom_range(0, 32'h3FF));
         for (int i = 0; i < 8; i++) begin
            datas[i] = 8'($urandom);
            if (addrs[i] >= 25'h2000 && addrs[i] <= 25'h3FFF) datas[i] = 8'hFF;
         end
         if (pass == 1) datas[4] = 8'h00;
         // Model: SG-1000 image with every byte in the 0x2000-0x3FFF hole equal to 0xFF.
         exp_sg    = (idx % 32) == 2;
         exp_ext   = exp_sg;
         hole_seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (addrs[i] >= 25'h2000 && addrs[i] <= 25'h3FFF) begin
               hole_seen = 1'b1;
               if (datas[i] != 8'hFF) exp_ext = 1'b0;
            end
         end
         exp_ext = exp_ext && hole_seen;
         start_download(idx);
         for (int i = 0; i < 8; i++) send_byte(addrs[i], datas[i], 1'b1);
         end_download();
         checks++;
         if (sg1000 !== exp_sg || extram !== exp_ext) begin
            errors++;
            $display("FAIL sg_qual pass %0d: sg1000=%b extram=%b, required %b/%b", pass, sg1000, extram, exp_sg, exp_ext);
         end
         checks++;
         if (cart_pages !== 6'((addrs[7] / 16384) % 64) || write_mismatches() !== 0) begin
            errors++;
            $display("FAIL sg_writes pass %0d: pages=%0d mismatches=%0d, required pages=%0d mismatches=0",
                     pass, cart_pages, write_mismatches(), (addrs[7] / 16384) % 64);
         end
      end
   endtask

   task automatic test_pages();
      logic [24:0] a;
      ack_en    = 1'b1;
      ack_delay = 2;
      clear_model();
      start_download(8'd0);
      send_byte(25'd0, 8'($urandom), 1'b1);
      send_byte(25'($urandom_range(1, 32'h7FFF)), 8'($urandom), 1'b1);
      send_byte(25'h8000, 8'($urandom), 1'b1);
      send_byte(25'hBFFF, 8'($urandom), 1'b1);
      repeat (2) @(negedge clk_sys);
      checks++;
      if (cart_pages !== 6'd2 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL pages_48k: pages=%0d ovf=%b, required 2/0", cart_pages, overflow);
      end
      send_byte(25'h100000, 8'h5A, 1'b1);
      @(negedge clk_sys);
      checks++;
      if (overflow !== 1'b1 || cart_pages !== 6'd2) begin
         errors++;
         $display("FAIL pages_out_of_range: ovf=%b pages=%0d, required 1/2", overflow, cart_pages);
      end
      end_download();
      checks++;
      if (got_q.size() !== 4 || write_mismatches() !== 0) begin
         errors++;
         $display("FAIL pages_writes: got %0d writes with %0d mismatches, required 4 in order", got_q.size(), write_mismatches());
      end
      clear_model();
      start_download(8'd0);
      a = 25'($urandom_range(0, 32'hFFFFE));
      send_byte(a, 8'($urandom), 1'b1);
      @(negedge clk_sys);
      checks++;
      if (cart_pages !== 6'((a / 16384) % 64)) begin
         errors++;
         $display("FAIL pages_random: addr=%h pages=%0d, required %0d", a, cart_pages, (a / 16384) % 64);
      end
      send_byte(25'hFFFFF, 8'($urandom), 1'b1);
      end_download();
      checks++;
      if (cart_pages !== 6'd63 || overflow !== 1'b0 || write_mismatches() !== 0) begin
         errors++;
         $display("FAIL pages_top: pages=%0d ovf=%b mismatches=%0d, required 63/0/0", cart_pages, overflow, write_mismatches());
      end
      ack_delay = 1;
   endtask

   task automatic test_reset_mid_write();
      ack_en = 1'b0;
      clear_model();
      start_download(8'd0);
      for (int i = 0; i < 3; i++) send_byte(25'($urandom_range(0, 32'hFFFFF)), 8'($urandom), 1'b0);
      checks++;
      if (mem_we !== 1'b1 || ioctl_wait !== 1'b1 || load_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup: we=%b wait=%b busy=%b with 3 queued, required 1/1/1", mem_we, ioctl_wait, load_busy);
      end
      #2;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || load_busy !== 1'b0 || ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: we=%b busy=%b wait=%b during reset, required 0/0/0", mem_we, load_busy, ioctl_wait);
      end
      clear_model();
      ack_en = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (20) @(negedge clk_sys);
      checks++;
      if (got_q.size() !== 0 || mem_we !== 1'b0 || done_cnt !== 0) begin
         errors++;
         $display("FAIL rst_no_writes: %0d writes, we=%b, %0d done pulses after release, required 0/0/0",
                  got_q.size(), mem_we, done_cnt);
      end
   endtask

   initial begin
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_sg1000();
      test_pages();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
